// File: rtl/message_stitcher_pkg.sv
// Shared message word layout, error codes and FSM state type for the stitcher.
package message_stitcher_pkg;

    // Message word field widths. The header flag takes one bit and the spare bits fill the rest.
    localparam int MSG_WIDTH            = 32;
    localparam int MSG_LENGTH_WIDTH     = 8;
    localparam int MSG_FORMATCODE_WIDTH = 4;
    localparam int MSG_MODULECODE_WIDTH = 8;
    localparam int MSG_ERRORCODE_WIDTH  = 4;
    localparam int MSG_SPARE_WIDTH      = MSG_WIDTH - 1 - MSG_LENGTH_WIDTH - MSG_FORMATCODE_WIDTH
                                          - MSG_MODULECODE_WIDTH - MSG_ERRORCODE_WIDTH;

    // err_code values; zero means no error has been seen since reset.
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ORPHAN  = 2'd1;
    localparam logic [1:0] ERR_TRUNC   = 2'd2;
    localparam logic [1:0] ERR_OVERLEN = 2'd3;

    // IDLE waits for a header, BODY collects body words, SKIP discards an over-length message.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BODY = 2'd1,
        ST_SKIP = 2'd2
    } state_t;

    // Header word layout, MSB first.
    typedef struct packed {
        logic                            is_header;
        logic [MSG_LENGTH_WIDTH-1:0]     length;
        logic [MSG_FORMATCODE_WIDTH-1:0] formatcode;
        logic [MSG_MODULECODE_WIDTH-1:0] modulecode;
        logic [MSG_ERRORCODE_WIDTH-1:0]  errorcode;
        logic [MSG_SPARE_WIDTH-1:0]      spare;
    } msg_header_t;

    // Builds a header word with the spare bits cleared.
    function automatic logic [MSG_WIDTH-1:0] make_header(
        input logic [MSG_LENGTH_WIDTH-1:0]     length,
        input logic [MSG_FORMATCODE_WIDTH-1:0] formatcode,
        input logic [MSG_MODULECODE_WIDTH-1:0] modulecode,
        input logic [MSG_ERRORCODE_WIDTH-1:0]  errorcode
    );
        msg_header_t h;
        h.is_header  = 1'b1;
        h.length     = length;
        h.formatcode = formatcode;
        h.modulecode = modulecode;
        h.errorcode  = errorcode;
        h.spare      = '0;
        return h;
    endfunction

endpackage

// File: rtl/message_stitcher.sv
// Reassembles header + body word streams into whole messages and flags malformed streams.
module message_stitcher
    import message_stitcher_pkg::*;
#(
    parameter int MAX_BODY  = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [MSG_WIDTH-1:0]          in_msg,
    input  logic                          in_nd,
    output logic [MSG_WIDTH-1:0]          out_header,
    output logic [MAX_BODY*MSG_WIDTH-1:0] out_body,
    output logic [MSG_LENGTH_WIDTH-1:0]   out_length,
    output logic                          out_nd,
    output logic                          err_nd,
    output logic [1:0]                    err_code,
    output logic                          error,
    output logic [CNT_WIDTH-1:0]          drop_count
);

    // Index must reach MAX_BODY-1 and the incremented value MAX_BODY without overflow.
    localparam int IDX_W = $clog2(MAX_BODY + 1);
    localparam logic [MSG_LENGTH_WIDTH-1:0] MAX_LEN = MSG_LENGTH_WIDTH'(MAX_BODY);

    // Working state of the message being collected.
    state_t                      state_reg, state_next;
    logic [IDX_W-1:0]            idx_reg, idx_next;
    logic [MSG_LENGTH_WIDTH-1:0] len_reg, len_next;
    logic [MSG_LENGTH_WIDTH-1:0] remaining_reg, remaining_next;
    logic [MSG_WIDTH-1:0]        header_reg, header_next;
    logic [MSG_WIDTH-1:0]        body_reg  [MAX_BODY];
    logic [MSG_WIDTH-1:0]        body_next [MAX_BODY];

    // Per-cycle decisions from the next-state logic.
    logic                        take_header;
    logic                        done_next;
    logic                        err_next;
    logic [1:0]                  code_next;
    logic [CNT_WIDTH-1:0]        drop_inc;

    // Registered outputs; the completed message is held until the next one finishes.
    logic [MSG_WIDTH-1:0]        out_header_reg;
    logic [MSG_WIDTH-1:0]        out_body_reg [MAX_BODY];
    logic [MSG_LENGTH_WIDTH-1:0] out_length_reg;
    logic                        out_nd_reg;
    logic                        err_nd_reg;
    logic [1:0]                  err_code_reg;
    logic                        error_reg;
    logic [CNT_WIDTH-1:0]        drop_count_reg, drop_count_next;
    logic [CNT_WIDTH:0]          drop_sum;

    // Fields of the incoming word.
    logic                        word_is_header;
    logic [MSG_LENGTH_WIDTH-1:0] word_length;
    logic                        idx_is_last;

    assign word_is_header = in_msg[MSG_WIDTH-1];
    assign word_length    = in_msg[MSG_WIDTH-2 -: MSG_LENGTH_WIDTH];
    assign idx_is_last    = (len_reg == MSG_LENGTH_WIDTH'(idx_reg) + MSG_LENGTH_WIDTH'(1));

    // Saturating accumulate of discarded words: the carry out pins the counter at all-ones.
    assign drop_sum        = {1'b0, drop_count_reg} + {1'b0, drop_inc};
    assign drop_count_next = drop_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : drop_sum[CNT_WIDTH-1:0];

    // Next-state logic: classify the word against the current state, then apply header rules.
    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        len_next       = len_reg;
        remaining_next = remaining_reg;
        header_next    = header_reg;
        body_next      = body_reg;
        take_header    = 1'b0;
        done_next      = 1'b0;
        err_next       = 1'b0;
        code_next      = ERR_NONE;
        drop_inc       = '0;

        if (in_nd) begin
            unique case (state_reg)
                ST_IDLE: begin
                    if (word_is_header) begin
                        take_header = 1'b1;
                    end else begin
                        err_next  = 1'b1;
                        code_next = ERR_ORPHAN;
                        drop_inc  = CNT_WIDTH'(1);
                    end
                end
                ST_BODY: begin
                    if (word_is_header) begin
                        // Partial message is abandoned; the words already held count as dropped.
                        err_next    = 1'b1;
                        code_next   = ERR_TRUNC;
                        drop_inc    = CNT_WIDTH'(idx_reg);
                        take_header = 1'b1;
                    end else begin
                        for (int k = 0; k < MAX_BODY; k++) begin
                            if (idx_reg == IDX_W'(k)) begin
                                body_next[k] = in_msg;
                            end
                        end
                        idx_next = idx_reg + IDX_W'(1);
                        if (idx_is_last) begin
                            done_next  = 1'b1;
                            state_next = ST_IDLE;
                        end
                    end
                end
                ST_SKIP: begin
                    if (word_is_header) begin
                        err_next    = 1'b1;
                        code_next   = ERR_TRUNC;
                        take_header = 1'b1;
                    end else begin
                        drop_inc       = CNT_WIDTH'(1);
                        remaining_next = remaining_reg - MSG_LENGTH_WIDTH'(1);
                        if (remaining_reg == MSG_LENGTH_WIDTH'(1)) begin
                            state_next = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase

            if (take_header) begin
                header_next = in_msg;
                len_next    = word_length;
                idx_next    = '0;
                for (int k = 0; k < MAX_BODY; k++) begin
                    body_next[k] = '0;
                end
                if (word_length == '0) begin
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end else if (word_length <= MAX_LEN) begin
                    state_next = ST_BODY;
                end else begin
                    // A truncation in the same cycle outranks the over-length report.
                    if (!err_next) begin
                        err_next  = 1'b1;
                        code_next = ERR_OVERLEN;
                    end
                    remaining_next = word_length;
                    state_next     = ST_SKIP;
                end
            end
        end
    end

    // Working-state registers; reset silently discards any partial message.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            idx_reg       <= '0;
            len_reg       <= '0;
            remaining_reg <= '0;
            header_reg    <= '0;
            for (int k = 0; k < MAX_BODY; k++) begin
                body_reg[k] <= '0;
            end
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            len_reg       <= len_next;
            remaining_reg <= remaining_next;
            header_reg    <= header_next;
            body_reg      <= body_next;
        end
    end

    // Output registers: capture the finished message, pulse strobes, track errors and drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_header_reg <= '0;
            out_length_reg <= '0;
            out_nd_reg     <= 1'b0;
            err_nd_reg     <= 1'b0;
            err_code_reg   <= ERR_NONE;
            error_reg      <= 1'b0;
            drop_count_reg <= '0;
            for (int k = 0; k < MAX_BODY; k++) begin
                out_body_reg[k] <= '0;
            end
        end else begin
            out_nd_reg     <= done_next;
            err_nd_reg     <= err_next;
            error_reg      <= error_reg | err_next;
            drop_count_reg <= drop_count_next;
            if (done_next) begin
                out_header_reg <= header_next;
                out_length_reg <= len_next;
                out_body_reg   <= body_next;
            end
            if (err_next) begin
                err_code_reg <= code_next;
            end
        end
    end

    // Body slot k occupies bits [k*W +: W] of the flat output bus.
    for (genvar gi = 0; gi < MAX_BODY; gi++) begin : g_body_out
        assign out_body[gi*MSG_WIDTH +: MSG_WIDTH] = out_body_reg[gi];
    end

    assign out_header = out_header_reg;
    assign out_length = out_length_reg;
    assign out_nd     = out_nd_reg;
    assign err_nd     = err_nd_reg;
    assign err_code   = err_code_reg;
    assign error      = error_reg;
    assign drop_count = drop_count_reg;

endmodule
